spi_axi_host_seq: RTL and testbench

- Synthesizable SPI host sequencer placed directly upstream of the spi_axi_master port of impl_axi. It replaces the bench's hand-driven CEB/SCLK/DATA waveforms.
- Accepts one command at a time: write, read, or set the picorv32 reset.
- Serializes each command into the spi_axi_master frame format, then polls the status word until the AXI transaction completes.
- Returns the status or read data on a response handshake. Used by the on-board loader and by system benches for firmware download and peripheral access.

---
 rtl/spi_axi_host_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_axi_host_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_axi_host_seq.sv
// SPI host sequencer for the spi_axi_master port of impl_axi.
// Takes one write / read / CPU-reset command at a time and serializes it
// into a 66-bit command frame. For write and read it then polls with 34-bit
// status frames until the AXI transaction completes, and for read it also
// fetches the data word. The result is returned on a valid/ready response.
module spi_axi_host_seq #(
  parameter int CLKDIV   = 2,
  parameter int GAP_BITS = 4,
  parameter int MAX_POLL = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        spi_CEB,
  output logic        spi_SCLK,
  output logic        spi_DATA,
  input  logic        spi_DOUT,
  output logic        busy
);

  // A gap of zero bit times is stretched to one so CEB always pulses high.
  localparam int GAP_CYC = ((GAP_BITS < 1) ? 1 : GAP_BITS) * 2 * CLKDIV;
  localparam int DIVW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GAPW    = $clog2(GAP_CYC + 1);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_CYC - 1);
  localparam logic [9:0]      POLL_MAX = 10'(MAX_POLL);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_POLL,
    S_RDAT,
    S_GAP,
    S_EVAL,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      r_from;
  logic [1:0]  r_op;
  logic [65:0] r_shift;
  logic [31:0] r_cap;
  logic        r_ceb;
  logic        r_sclk;
  logic [DIVW-1:0] r_div;
  logic [6:0]  r_bitIdx;
  logic [6:0]  r_lastIdx;
  logic [GAPW-1:0] r_gap;
  logic [9:0]  r_poll;
  logic [31:0] r_rspData;
  logic        r_rspErr;

  logic        w_shifting;
  logic        w_halfEnd;
  logic        w_frameDone;
  logic        w_gapDone;
  logic        w_done;
  logic        w_timeout;
  logic        w_start;
  logic [65:0] w_frame;
  logic [6:0]  w_lastIdx;
  logic        w_setRsp;
  logic [31:0] w_rspData;
  logic        w_rspErr;

  assign w_shifting  = (r_state == S_CMD) || (r_state == S_POLL) || (r_state == S_RDAT);
  assign w_halfEnd   = (r_div == DIV_LAST);
  assign w_frameDone = w_shifting && w_halfEnd && r_sclk && (r_bitIdx == r_lastIdx);
  assign w_gapDone   = (r_state == S_GAP) && (r_gap == GAP_LAST);
  // Reads may finish with status[1] still set; writes need both low bits clear.
  assign w_done      = (r_op == OP_RD) ? (!r_cap[2] && !r_cap[0]) : (r_cap[1:0] == 2'b00);
  assign w_timeout   = (r_poll == POLL_MAX);

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;
  assign spi_CEB   = r_ceb;
  assign spi_SCLK  = r_sclk;
  assign spi_DATA  = r_shift[65];

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic plus frame-load and response-capture strobes.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_frame   = '0;
    w_lastIdx = 7'd33;
    w_setRsp  = 1'b0;
    w_rspData = '0;
    w_rspErr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_RSV) begin
            w_next   = S_RESP;
            w_setRsp = 1'b1;
            w_rspErr = 1'b1;
          end else begin
            w_next    = S_CMD;
            w_start   = 1'b1;
            w_lastIdx = 7'd65;
            case (cmd_op)
              OP_WR:   w_frame = {2'b10, cmd_addr, cmd_wdata};
              OP_RD:   w_frame = {2'b01, cmd_addr, 32'h0};
              default: w_frame = {2'b00, 63'h0, cmd_wdata[0]};
            endcase
          end
        end
      end
      S_CMD, S_POLL, S_RDAT: begin
        if (w_frameDone) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_gapDone) begin
          if (r_from == S_CMD) begin
            if (r_op == OP_RST) begin
              w_next   = S_RESP;
              w_setRsp = 1'b1;
            end else begin
              w_next  = S_POLL;
              w_start = 1'b1;
            end
          end else if (r_from == S_POLL) begin
            w_next = S_EVAL;
          end else begin
            w_next    = S_RESP;
            w_setRsp  = 1'b1;
            w_rspData = r_cap;
          end
        end
      end
      S_EVAL: begin
        if (w_done) begin
          if (r_op == OP_RD) begin
            w_next  = S_RDAT;
            w_start = 1'b1;
            w_frame = {2'b11, 64'h0};
          end else begin
            w_next    = S_RESP;
            w_setRsp  = 1'b1;
            w_rspData = r_cap;
          end
        end else if (w_timeout) begin
          w_next    = S_RESP;
          w_setRsp  = 1'b1;
          w_rspData = r_cap;
          w_rspErr  = 1'b1;
        end else begin
          w_next  = S_POLL;
          w_start = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit engine: SCLK low half then high half per bit, DOUT sampled on the rise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_op      <= '0;
      r_shift   <= '0;
      r_cap     <= '0;
      r_ceb     <= 1'b1;
      r_sclk    <= 1'b0;
      r_div     <= '0;
      r_bitIdx  <= '0;
      r_lastIdx <= '0;
      r_from    <= S_IDLE;
      r_poll    <= '0;
    end else begin
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_op   <= cmd_op;
        r_poll <= '0;
      end
      if (w_start) begin
        r_shift   <= w_frame;
        r_lastIdx <= w_lastIdx;
        r_bitIdx  <= '0;
        r_div     <= '0;
        r_sclk    <= 1'b0;
        r_ceb     <= 1'b0;
        if (w_next == S_POLL) r_poll <= r_poll + 10'd1;
      end else if (w_shifting) begin
        if (w_halfEnd) begin
          r_div <= '0;
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_cap  <= {r_cap[30:0], spi_DOUT};
          end else begin
            r_sclk <= 1'b0;
            if (r_bitIdx == r_lastIdx) begin
              r_ceb   <= 1'b1;
              r_shift <= '0;
              r_from  <= r_state;
            end else begin
              r_shift  <= {r_shift[64:0], 1'b0};
              r_bitIdx <= r_bitIdx + 7'd1;
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  // Inter-frame gap counter, CEB held high while it runs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 r_gap <= '0;
    else if (r_state != S_GAP) r_gap <= '0;
    else if (w_gapDone)       r_gap <= '0;
    else                      r_gap <= r_gap + 1'b1;
  end

  // Response registers, loaded on entry to RESP and held until accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else if (w_setRsp) begin
      r_rspData <= w_rspData;
      r_rspErr  <= w_rspErr;
    end
  end

endmodule

// File: tb/tb_spi_axi_host_seq.sv
// Directed bench for spi_axi_host_seq with a scripted spi_axi_master slave.
module tb_spi_axi_host_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        spi_CEB;
  logic        spi_SCLK;
  logic        spi_DATA;
  logic        spi_DOUT;
  logic        busy;

  int nChecks = 0;
  int nPass   = 0;

  logic        slvDout = 1'b0;
  logic [65:0] rxBits = '0;
  int          rxCnt = 0;
  int          txIdx = 0;
  logic [31:0] txWord = '0;
  logic [31:0] statQ[$];
  logic [31:0] defaultStat = '0;
  logic [31:0] rdWord = 32'h0000_02B3;
  logic [65:0] frBits[$];
  int          frLen[$];

  int highRun = 0;
  int minGap = 1000000;
  bit seenFrame = 1'b0;
  int sclkViol = 0;
  bit rspSeen = 1'b0;

  logic        gotOk;
  logic [31:0] gotData;
  logic        gotErr;

  assign spi_DOUT = slvDout;

  spi_axi_host_seq #(.CLKDIV(2), .GAP_BITS(4), .MAX_POLL(3)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_CEB(spi_CEB), .spi_SCLK(spi_SCLK), .spi_DATA(spi_DATA), .spi_DOUT(spi_DOUT),
    .busy(busy)
  );

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  // Slave: a new frame starts when CEB falls.
  always @(negedge spi_CEB) begin
    rxBits = '0; rxCnt = 0; txIdx = 0; txWord = '0; slvDout = 1'b0;
  end

  // Slave: DATA is captured MSB first on each SCLK rise.
  always @(posedge spi_SCLK) begin
    rxBits = {rxBits[64:0], spi_DATA};
    rxCnt++;
  end

  // Slave: after the 2-bit opcode picks the reply word, DOUT advances on each SCLK fall.
  always @(negedge spi_SCLK) begin
    txIdx++;
    if (txIdx == 2) begin
      if (rxBits[1:0] == 2'b00) begin
        if (statQ.size() > 0) txWord = statQ.pop_front();
        else                  txWord = defaultStat;
      end else if (rxBits[1:0] == 2'b11) txWord = rdWord;
      else txWord = '0;
    end
    slvDout = (txIdx >= 2 && txIdx <= 33) ? txWord[33 - txIdx] : 1'b0;
  end

  // Slave: a finished (or aborted) frame is logged when CEB rises.
  always @(posedge spi_CEB) begin
    if (rxCnt > 0) begin
      frBits.push_back(rxBits);
      frLen.push_back(rxCnt);
    end
  end

  // Bus monitor: shortest CEB-high run between frames, SCLK activity with CEB high, responses.
  always @(negedge CLK) begin
    if (rsp_valid) rspSeen = 1'b1;
    if (spi_CEB && spi_SCLK) sclkViol++;
    if (!RST) highRun = 0;
    else if (spi_CEB) highRun++;
    else begin
      if (seenFrame && highRun > 0 && highRun < minGap) minGap = highRun;
      highRun = 0;
      seenFrame = 1'b1;
    end
  end

  function automatic int frameLen(int i);
    return (i < frLen.size()) ? frLen[i] : -1;
  endfunction

  function automatic logic [65:0] frameBits(int i);
    return (i < frBits.size()) ? frBits[i] : '1;
  endfunction

  task automatic clearRecord();
    frBits.delete(); frLen.delete(); statQ.delete();
    rxCnt = 0; minGap = 1000000; seenFrame = 1'b0; sclkViol = 0; rspSeen = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge CLK);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
  endtask

  task automatic waitRsp();
    gotOk = 1'b0; gotData = 'x; gotErr = 1'bx;
    for (int i = 0; i < 20000 && !gotOk; i++) begin
      if (rsp_valid) begin gotOk = 1'b1; gotData = rsp_data; gotErr = rsp_err; end
      else @(negedge CLK);
    end
  endtask

  task automatic acceptRsp();
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    nChecks++; if (spi_CEB !== 1'b1) $display("[TB] FAIL reset_ceb: got %b expected 1", spi_CEB); else nPass++;
    nChecks++; if (spi_SCLK !== 1'b0) $display("[TB] FAIL reset_sclk: got %b expected 0", spi_SCLK); else nPass++;
    nChecks++; if (spi_DATA !== 1'b0) $display("[TB] FAIL reset_data: got %b expected 0", spi_DATA); else nPass++;
    nChecks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else nPass++;
    nChecks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else nPass++;
    nChecks++; if (rsp_data !== 32'h0) $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); else nPass++;
    nChecks++; if (rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else nPass++;
  endtask

  task automatic test_write();
    clearRecord();
    statQ.push_back(32'h3); statQ.push_back(32'h0);
    applyStimulus(2'b00, 32'h0000_0400, 32'hA5A5_0FFF);
    waitRsp();
    nChecks++; if (gotOk !== 1'b1) $display("[TB] FAIL wr_rsp_seen: got %b expected 1", gotOk); else nPass++;
    nChecks++; if (gotData !== 32'h0) $display("[TB] FAIL wr_rsp_data: got %h expected 0", gotData); else nPass++;
    nChecks++; if (gotErr !== 1'b0) $display("[TB] FAIL wr_rsp_err: got %b expected 0", gotErr); else nPass++;
    acceptRsp();
    nChecks++; if (frLen.size() != 3) $display("[TB] FAIL wr_frames: got %0d expected 3", frLen.size()); else nPass++;
    nChecks++; if (frameLen(0) != 66) $display("[TB] FAIL wr_cmd_len: got %0d expected 66", frameLen(0)); else nPass++;
    nChecks++; if (frameBits(0) !== {2'b10, 32'h0000_0400, 32'hA5A5_0FFF})
      $display("[TB] FAIL wr_cmd_bits: got %h expected %h", frameBits(0), {2'b10, 32'h0000_0400, 32'hA5A5_0FFF}); else nPass++;
    nChecks++; if (frameLen(1) != 34 || frameLen(2) != 34)
      $display("[TB] FAIL wr_stat_len: got %0d,%0d expected 34,34", frameLen(1), frameLen(2)); else nPass++;
    nChecks++; if (frameBits(1) !== 66'h0 || frameBits(2) !== 66'h0)
      $display("[TB] FAIL wr_stat_bits: got %h,%h expected 0,0", frameBits(1), frameBits(2)); else nPass++;
    nChecks++; if (minGap < 16) $display("[TB] FAIL wr_gap: got %0d expected >=16", minGap); else nPass++;
    nChecks++; if (sclkViol != 0) $display("[TB] FAIL wr_sclk_idle: got %0d expected 0", sclkViol); else nPass++;
  endtask

  task automatic test_read();
    clearRecord();
    // Status 2 has bit1 set: still complete for a read, so only two polls.
    statQ.push_back(32'h5); statQ.push_back(32'h2);
    applyStimulus(2'b01, 32'h0000_0408, 32'hFFFF_FFFF);
    waitRsp();
    nChecks++; if (gotOk !== 1'b1) $display("[TB] FAIL rd_rsp_seen: got %b expected 1", gotOk); else nPass++;
    nChecks++; if (gotData !== 32'h0000_02B3) $display("[TB] FAIL rd_rsp_data: got %h expected 000002b3", gotData); else nPass++;
    nChecks++; if (gotErr !== 1'b0) $display("[TB] FAIL rd_rsp_err: got %b expected 0", gotErr); else nPass++;
    acceptRsp();
    nChecks++; if (frLen.size() != 4) $display("[TB] FAIL rd_frames: got %0d expected 4", frLen.size()); else nPass++;
    nChecks++; if (frameBits(0) !== {2'b01, 32'h0000_0408, 32'h0})
      $display("[TB] FAIL rd_cmd_bits: got %h expected %h", frameBits(0), {2'b01, 32'h0000_0408, 32'h0}); else nPass++;
    nChecks++; if (frameLen(1) != 34 || frameLen(2) != 34 || frameLen(3) != 34)
      $display("[TB] FAIL rd_frame_len: got %0d,%0d,%0d expected 34,34,34", frameLen(1), frameLen(2), frameLen(3)); else nPass++;
    nChecks++; if (frameBits(3) !== 66'h3_0000_0000)
      $display("[TB] FAIL rd_rdat_bits: got %h expected 300000000", frameBits(3)); else nPass++;
  endtask

  task automatic test_cpu_reset();
    clearRecord();
    applyStimulus(2'b10, 32'hDEAD_BEEF, 32'h0000_0001);
    waitRsp();
    nChecks++; if (gotOk !== 1'b1) $display("[TB] FAIL rst_rsp_seen: got %b expected 1", gotOk); else nPass++;
    nChecks++; if (gotData !== 32'h0 || gotErr !== 1'b0)
      $display("[TB] FAIL rst_rsp: got %h/%b expected 0/0", gotData, gotErr); else nPass++;
    acceptRsp();
    repeat (50) @(negedge CLK);
    nChecks++; if (frLen.size() != 1) $display("[TB] FAIL rst_frames: got %0d expected 1", frLen.size()); else nPass++;
    nChecks++; if (frameLen(0) != 66 || frameBits(0) !== 66'h1)
      $display("[TB] FAIL rst_frame: got %0d bits %h expected 66 bits 1", frameLen(0), frameBits(0)); else nPass++;
  endtask

  task automatic test_timeout();
    clearRecord();
    defaultStat = 32'h2;
    applyStimulus(2'b00, 32'h0000_0404, 32'h0000_0001);
    waitRsp();
    nChecks++; if (gotOk !== 1'b1) $display("[TB] FAIL to_rsp_seen: got %b expected 1", gotOk); else nPass++;
    nChecks++; if (gotErr !== 1'b1) $display("[TB] FAIL to_rsp_err: got %b expected 1", gotErr); else nPass++;
    nChecks++; if (gotData !== 32'h2) $display("[TB] FAIL to_rsp_data: got %h expected 2", gotData); else nPass++;
    acceptRsp();
    defaultStat = 32'h0;
    nChecks++; if (frLen.size() != 4) $display("[TB] FAIL to_frames: got %0d expected 4", frLen.size()); else nPass++;
  endtask

  task automatic test_back_to_back();
    int badValid = 0;
    int badData = 0;
    int badReady = 0;
    clearRecord();
    statQ.push_back(32'h0000_00F0);
    applyStimulus(2'b00, 32'h0000_0100, 32'h1234_5678);
    waitRsp();
    nChecks++; if (gotData !== 32'h0000_00F0) $display("[TB] FAIL bp_rsp_data: got %h expected 000000f0", gotData); else nPass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b1) badValid++;
      if (rsp_data !== 32'h0000_00F0) badData++;
      if (cmd_ready !== 1'b0) badReady++;
    end
    nChecks++; if (badValid != 0) $display("[TB] FAIL bp_valid_hold: got %0d drops expected 0", badValid); else nPass++;
    nChecks++; if (badData != 0) $display("[TB] FAIL bp_data_hold: got %0d changes expected 0", badData); else nPass++;
    nChecks++; if (badReady != 0) $display("[TB] FAIL bp_cmd_ready: got %0d highs expected 0", badReady); else nPass++;
    acceptRsp();
    nChecks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("[TB] FAIL bp_release: got ready %b valid %b expected 1 0", cmd_ready, rsp_valid); else nPass++;
    clearRecord();
    applyStimulus(2'b11, 32'h0000_0200, 32'h0000_0001);
    waitRsp();
    nChecks++; if (gotOk !== 1'b1 || gotErr !== 1'b1 || gotData !== 32'h0)
      $display("[TB] FAIL rsv_rsp: got ok %b err %b data %h expected 1 1 0", gotOk, gotErr, gotData); else nPass++;
    acceptRsp();
    nChecks++; if (frLen.size() != 0 || seenFrame)
      $display("[TB] FAIL rsv_no_frame: got %0d frames expected 0", frLen.size()); else nPass++;
  endtask

  task automatic test_reset_abort();
    bit reached = 1'b0;
    clearRecord();
    applyStimulus(2'b00, 32'h0000_0010, 32'h0000_1234);
    for (int i = 0; i < 5000 && !reached; i++) begin
      if (!spi_CEB && rxCnt >= 30) reached = 1'b1;
      else @(negedge CLK);
    end
    nChecks++; if (!reached) $display("[TB] FAIL ab_reach_bit30: got 0 expected 1"); else nPass++;
    RST = 1'b0;
    #1;
    nChecks++; if (spi_CEB !== 1'b1 || spi_SCLK !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL ab_outputs: got ceb %b sclk %b busy %b expected 1 0 0", spi_CEB, spi_SCLK, busy); else nPass++;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    rspSeen = 1'b0;
    repeat (10) @(negedge CLK);
    nChecks++; if (rspSeen) $display("[TB] FAIL ab_no_rsp: got 1 expected 0"); else nPass++;
    clearRecord();
    statQ.push_back(32'h0);
    applyStimulus(2'b00, 32'h0000_0020, 32'hCAFE_0001);
    waitRsp();
    nChecks++; if (gotOk !== 1'b1 || gotErr !== 1'b0 || gotData !== 32'h0)
      $display("[TB] FAIL ab_next_rsp: got ok %b err %b data %h expected 1 0 0", gotOk, gotErr, gotData); else nPass++;
    acceptRsp();
    nChecks++; if (frLen.size() != 2 || frameBits(0) !== {2'b10, 32'h0000_0020, 32'hCAFE_0001})
      $display("[TB] FAIL ab_next_frames: got %0d frames first %h", frLen.size(), frameBits(0)); else nPass++;
  endtask

  // Test sequence.
  initial begin
    repeat (3) @(negedge CLK);
    test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    test_write();
    test_read();
    test_cpu_reset();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
